game_timer: RTL

- Elapsed-play-time counter for a Sudoku round.
- Divides the system clock into a 1 Hz tick and counts whole seconds since round start.
- Exposes the count as an 11-bit `timer` bus, which the downstream score stage consumes directly.
- Handles start, pause/resume, solved-freeze and time-limit expiry, so downstream logic sees a stable, saturated value.

---
 rtl/sudoku_pkg.sv | 25 ++
 rtl/sec_prescaler.sv | 30 +++
 rtl/game_timer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku round datapath: timer state encoding and
// the elapsed-time bus width consumed by the score stage.
package sudoku_pkg;

  localparam int TIMER_W = 11;

  localparam logic [2:0] TS_IDLE    = 3'd0;
  localparam logic [2:0] TS_RUNNING = 3'd1;
  localparam logic [2:0] TS_PAUSED  = 3'd2;
  localparam logic [2:0] TS_DONE    = 3'd3;
  localparam logic [2:0] TS_EXPIRED = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = TS_IDLE,
    ST_RUNNING = TS_RUNNING,
    ST_PAUSED  = TS_PAUSED,
    ST_DONE    = TS_DONE,
    ST_EXPIRED = TS_EXPIRED
  } timer_state_e;

  function automatic int limit_seconds(input int minutes);
    return minutes * 60;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_FREQ_HZ enabled cycles.
// clr restarts the fractional second; a disabled prescaler keeps its count.
module sec_prescaler #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && !clr && (cnt == TERM);

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Elapsed-play-time counter for a Sudoku round, saturating at the round limit.
// Define GAME_TIMER_BCD_EN to add mm:ss BCD digit outputs for the display.
module game_timer
  import sudoku_pkg::*;
#(
  parameter int CLK_FREQ_HZ        = 50_000_000,
  parameter int TIME_LIMIT_MINUTES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               solved,
  output logic [TIMER_W-1:0] timer,
  output logic               running,
  output logic               expired,
  output logic               sec_tick
`ifdef GAME_TIMER_BCD_EN
  ,
  output logic [3:0]         min_tens,
  output logic [3:0]         min_ones,
  output logic [3:0]         sec_tens,
  output logic [3:0]         sec_ones
`endif
);

  localparam int LIMIT_S = limit_seconds(TIME_LIMIT_MINUTES);
  localparam logic [TIMER_W-1:0] LIMIT_V = TIMER_W'(LIMIT_S);

  if (LIMIT_S < 1 || LIMIT_S > (1 << TIMER_W) - 1) begin : g_limit_check
    $error("game_timer: TIME_LIMIT_MINUTES*60 must lie in 1..2047");
  end

  timer_state_e       state, state_n;
  logic [TIMER_W-1:0] timer_n;
  logic [TIMER_W-1:0] timer_inc;
  logic               sec_tick_n;
  logic               tick;
  logic               clr;

  sec_prescaler #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_RUNNING),
    .clr   (clr),
    .tick  (tick)
  );

  assign timer_inc = timer + 1'b1;

  // Event priority below reset: start > solved > pause > tick.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    sec_tick_n = 1'b0;
    clr        = 1'b0;
    if (start) begin
      state_n = ST_RUNNING;
      timer_n = '0;
      clr     = 1'b1;
    end else begin
      case (state)
        ST_RUNNING: begin
          if (solved) begin
            state_n = ST_DONE;
          end else if (pause) begin
            state_n = ST_PAUSED;
          end else if (tick) begin
            sec_tick_n = 1'b1;
            timer_n    = timer_inc;
            if (timer_inc == LIMIT_V) state_n = ST_EXPIRED;
          end
        end
        ST_PAUSED: begin
          if (solved)     state_n = ST_DONE;
          else if (pause) state_n = ST_RUNNING;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      timer    <= '0;
      sec_tick <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      sec_tick <= sec_tick_n;
    end
  end

  assign running = (state == ST_RUNNING);
  assign expired = (state == ST_EXPIRED);

`ifdef GAME_TIMER_BCD_EN
  // Cascaded digits advance on exactly the edges where timer increments.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (sec_tick_n) begin
      if (sec_ones == 4'd9) begin
        sec_ones <= '0;
        if (sec_tens == 4'd5) begin
          sec_tens <= '0;
          if (min_ones == 4'd9) begin
            min_ones <= '0;
            min_tens <= (min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1;
          end else begin
            min_ones <= min_ones + 4'd1;
          end
        end else begin
          sec_tens <= sec_tens + 4'd1;
        end
      end else begin
        sec_ones <= sec_ones + 4'd1;
      end
    end
  end
`endif

endmodule
